// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared encodings for the 5-stage MIPS pipeline controller: opcode and
//   function-field constants, ALU operation codes, forwarding select codes,
//   the per-stage control structs, and the forwarding priority helper.
//   No ports; imported by the decoder and the controller top.
package pipe_ctrl_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_t;

  // Controls consumed in EX
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_t alu_op;
    logic    sel_write;
    logic    jmp;
    logic    jor_jr;
  } ex_ctrl_t;

  // Controls consumed in MEM
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  // Controls consumed in WB
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic write_src;
  } wb_ctrl_t;

  // Full decoded control word, as held in ID/EX
  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  // EX/MEM only needs what is still ahead of it
  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } exmem_ctrl_t;

  // The younger producer (EX/MEM) wins over the older one (MEM/WB);
  // register 0 is never forwarded because it always reads as zero.
  function automatic fwd_sel_t fwd_select(
    input logic       exmem_wr,
    input logic [4:0] exmem_rd,
    input logic       memwb_wr,
    input logic [4:0] memwb_rd,
    input logic [4:0] src
  );
    fwd_sel_t sel;
    sel = FWD_REGFILE;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundle of every signal between the pipeline datapath and its controller.
//   Taps from the datapath: Opc/Func (IF/ID instruction fields), zero (EX/MEM
//   ALU flag) and the pipeline register numbers used for hazard and
//   forwarding decisions. Controls to the datapath: EX-stage selects, MEM
//   stage enables, WB-stage selects, forwarding selects and hazard controls.
//   modport master : datapath side (drives taps, receives controls)
//   modport slave  : controller side (receives taps, drives controls)
interface pipe_ctrl_if;

  // Datapath taps
  logic [5:0] Opc;
  logic [5:0] Func;
  logic       zero;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic [4:0] ID_EX_Rs;
  logic [4:0] ID_EX_Rt;
  logic [4:0] EX_MEM_Rd;
  logic [4:0] MEM_WB_Rd;

  // EX-stage controls
  logic       RegDst;
  logic       ALUSrc;
  logic       SelWrite;
  logic       Jmp;
  logic       JorJr;
  logic [2:0] ALUOp;
  logic [1:0] selA;
  logic [1:0] selB;

  // MEM-stage controls
  logic       PCSrc;
  logic       MemRead;
  logic       MemWrite;

  // WB-stage controls
  logic       RegWrite;
  logic       MemToReg;
  logic       WriteSrc;

  // Hazard controls
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       Bubble;

  modport master (
    output Opc, Func, zero,
    output IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, EX_MEM_Rd, MEM_WB_Rd,
    input  RegDst, ALUSrc, SelWrite, Jmp, JorJr, ALUOp, selA, selB,
    input  PCSrc, MemRead, MemWrite,
    input  RegWrite, MemToReg, WriteSrc,
    input  PCWrite, IF_ID_Write, Bubble
  );

  modport slave (
    input  Opc, Func, zero,
    input  IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, EX_MEM_Rd, MEM_WB_Rd,
    output RegDst, ALUSrc, SelWrite, Jmp, JorJr, ALUOp, selA, selB,
    output PCSrc, MemRead, MemWrite,
    output RegWrite, MemToReg, WriteSrc,
    output PCWrite, IF_ID_Write, Bubble
  );

endinterface

// File: rtl/pipe_decoder.sv
// pipe_decoder
//   Purely combinational instruction decoder for the ID stage.
//   Ports:
//     opc  in  6  instruction bits [31:26]
//     func in  6  instruction bits [5:0], only meaningful for R-type
//     ctrl out    full control word (ctrl_t); all-zero for any instruction
//                 not in the supported set, which makes it a NOP
module pipe_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opc,
  input  logic [5:0] func,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opc)
      OPC_RTYPE: begin
        case (func)
          FUNC_ADD: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
            ctrl.ex.alu_op    = ALU_ADD;
          end
          FUNC_SUB: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
            ctrl.ex.alu_op    = ALU_SUB;
          end
          FUNC_AND: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
            ctrl.ex.alu_op    = ALU_AND;
          end
          FUNC_OR: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
            ctrl.ex.alu_op    = ALU_OR;
          end
          FUNC_SLT: begin
            ctrl.ex.reg_dst   = 1'b1;
            ctrl.wb.reg_write = 1'b1;
            ctrl.ex.alu_op    = ALU_SLT;
          end
          // jr is R-type but redirects instead of writing a register
          FUNC_JR: begin
            ctrl.ex.jmp    = 1'b1;
            ctrl.ex.jor_jr = 1'b1;
          end
          default: ;
        endcase
      end
      OPC_ADDI: begin
        ctrl.ex.alu_src   = 1'b1;
        ctrl.wb.reg_write = 1'b1;
        ctrl.ex.alu_op    = ALU_ADD;
      end
      OPC_SLTI: begin
        ctrl.ex.alu_src   = 1'b1;
        ctrl.wb.reg_write = 1'b1;
        ctrl.ex.alu_op    = ALU_SLT;
      end
      OPC_LW: begin
        ctrl.ex.alu_src    = 1'b1;
        ctrl.mem.mem_read  = 1'b1;
        ctrl.wb.mem_to_reg = 1'b1;
        ctrl.wb.reg_write  = 1'b1;
      end
      OPC_SW: begin
        ctrl.ex.alu_src    = 1'b1;
        ctrl.mem.mem_write = 1'b1;
      end
      // Comparison is done as a subtract; the MEM stage checks zero
      OPC_BEQ: begin
        ctrl.mem.branch = 1'b1;
        ctrl.ex.alu_op  = ALU_SUB;
      end
      OPC_J: begin
        ctrl.ex.jmp = 1'b1;
      end
      // jal writes the return address into r31 via SelWrite/WriteSrc
      OPC_JAL: begin
        ctrl.ex.jmp       = 1'b1;
        ctrl.ex.sel_write = 1'b1;
        ctrl.wb.write_src = 1'b1;
        ctrl.wb.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Sequencing controller for the 5-stage MIPS pipeline. Decodes the ID
//   instruction, carries its control through ID/EX, EX/MEM and MEM/WB
//   control registers, and resolves load-use stalls, operand forwarding and
//   control-flow squash (jump in EX, taken branch in MEM).
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset; clears all in-flight control
//     bus  pipe_ctrl_if.slave  datapath taps in, datapath controls out
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  ctrl_t       dec_ctrl;
  ctrl_t       id_ctrl;
  ctrl_t       idex_d,    idex_q;
  exmem_ctrl_t exmem_d,   exmem_q;
  wb_ctrl_t    memwb_d,   memwb_q;
  logic        kill_id_d, kill_id_q;

  logic pc_src;
  logic jmp_out;
  logic redirect;
  logic load_use;
  logic stall;

  pipe_decoder u_decoder (
    .opc  (bus.Opc),
    .func (bus.Func),
    .ctrl (dec_ctrl)
  );

  // Hazard and redirect resolution. A taken branch in MEM is older than a
  // jump in EX, so the jump is masked whenever the branch fires (the
  // datapath PC mux gives Jmp priority). kill_id turns the instruction that
  // was fetched during the redirect cycle into a NOP; the load-use check is
  // suppressed both on redirect and while that killed instruction sits in
  // ID, since neither of those instructions will ever execute.
  always_comb begin
    pc_src   = exmem_q.mem.branch & bus.zero;
    jmp_out  = idex_q.ex.jmp & ~pc_src;
    redirect = jmp_out | pc_src;

    load_use = idex_q.mem.mem_read && (bus.ID_EX_Rt != 5'd0) &&
               ((bus.ID_EX_Rt == bus.IF_ID_Rs) || (bus.ID_EX_Rt == bus.IF_ID_Rt));
    stall    = load_use & ~redirect & ~kill_id_q;

    id_ctrl  = kill_id_q ? '0 : dec_ctrl;
  end

  // Next values of the stage control registers. A stall or a redirect puts
  // a bubble into ID/EX; only a taken branch also has a wrong-path
  // instruction sitting in EX that must be dropped before EX/MEM.
  always_comb begin
    idex_d = id_ctrl;
    if (redirect || stall) begin
      idex_d = '0;
    end

    exmem_d.mem = idex_q.mem;
    exmem_d.wb  = idex_q.wb;
    if (pc_src) begin
      exmem_d = '0;
    end

    memwb_d   = exmem_q.wb;
    kill_id_d = redirect;
  end

  // Stage control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      kill_id_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      kill_id_q <= kill_id_d;
    end
  end

  // Forwarding selects for the two ALU operands currently in EX
  always_comb begin
    bus.selA = fwd_select(exmem_q.wb.reg_write, bus.EX_MEM_Rd,
                          memwb_q.reg_write, bus.MEM_WB_Rd, bus.ID_EX_Rs);
    bus.selB = fwd_select(exmem_q.wb.reg_write, bus.EX_MEM_Rd,
                          memwb_q.reg_write, bus.MEM_WB_Rd, bus.ID_EX_Rt);
  end

  // Each control is presented in the stage that consumes it
  always_comb begin
    bus.RegDst      = idex_q.ex.reg_dst;
    bus.ALUSrc      = idex_q.ex.alu_src;
    bus.ALUOp       = idex_q.ex.alu_op;
    bus.SelWrite    = idex_q.ex.sel_write;
    bus.JorJr       = idex_q.ex.jor_jr;
    bus.Jmp         = jmp_out;

    bus.PCSrc       = pc_src;
    bus.MemRead     = exmem_q.mem.mem_read;
    bus.MemWrite    = exmem_q.mem.mem_write;

    bus.RegWrite    = memwb_q.reg_write;
    bus.MemToReg    = memwb_q.mem_to_reg;
    bus.WriteSrc    = memwb_q.write_src;

    bus.PCWrite     = ~stall;
    bus.IF_ID_Write = ~stall;
    bus.Bubble      = stall;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed bench for pipe_ctrl. Each step drives the datapath taps for one
//   cycle and pushes the control values that cycle (or a later one) must
//   show into a scoreboard; the scoreboard entries due in a cycle are popped
//   and compared half a clock after the inputs settle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef enum int {
    S_REGDST, S_ALUSRC, S_SELWRITE, S_JMP, S_JORJR, S_ALUOP, S_SELA, S_SELB,
    S_PCSRC, S_MEMREAD, S_MEMWRITE, S_REGWRITE, S_MEMTOREG, S_WRITESRC,
    S_PCWRITE, S_IFIDWRITE, S_BUBBLE
  } sig_e;

  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [2:0] val;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Returns the DUT output selected by s, zero-extended to 3 bits
  function automatic logic [2:0] get_sig(sig_e s);
    case (s)
      S_REGDST:    return {2'b00, bus.RegDst};
      S_ALUSRC:    return {2'b00, bus.ALUSrc};
      S_SELWRITE:  return {2'b00, bus.SelWrite};
      S_JMP:       return {2'b00, bus.Jmp};
      S_JORJR:     return {2'b00, bus.JorJr};
      S_ALUOP:     return bus.ALUOp;
      S_SELA:      return {1'b0, bus.selA};
      S_SELB:      return {1'b0, bus.selB};
      S_PCSRC:     return {2'b00, bus.PCSrc};
      S_MEMREAD:   return {2'b00, bus.MemRead};
      S_MEMWRITE:  return {2'b00, bus.MemWrite};
      S_REGWRITE:  return {2'b00, bus.RegWrite};
      S_MEMTOREG:  return {2'b00, bus.MemToReg};
      S_WRITESRC:  return {2'b00, bus.WriteSrc};
      S_PCWRITE:   return {2'b00, bus.PCWrite};
      S_IFIDWRITE: return {2'b00, bus.IF_ID_Write};
      S_BUBBLE:    return {2'b00, bus.Bubble};
      default:     return 3'bxxx;
    endcase
  endfunction

  // Schedule an expected value 'ahead' cycles from now
  task automatic push_exp(input int ahead, input string tag, input sig_e s,
                          input logic [2:0] v);
    exp_t e;
    e.cyc = cyc + ahead;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive the datapath taps for the current cycle
  task automatic apply_stimulus(input logic [5:0] opc, input logic [5:0] func,
                                input logic [4:0] if_rs, input logic [4:0] if_rt,
                                input logic [4:0] ex_rs, input logic [4:0] ex_rt,
                                input logic [4:0] mem_rd, input logic [4:0] wb_rd,
                                input logic z);
    bus.Opc       = opc;
    bus.Func      = func;
    bus.IF_ID_Rs  = if_rs;
    bus.IF_ID_Rt  = if_rt;
    bus.ID_EX_Rs  = ex_rs;
    bus.ID_EX_Rt  = ex_rt;
    bus.EX_MEM_Rd = mem_rd;
    bus.MEM_WB_Rd = wb_rd;
    bus.zero      = z;
  endtask

  // Pop and compare every scoreboard entry due this cycle
  task automatic check_output();
    exp_t       keep[$];
    logic [2:0] obs;
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        obs = get_sig(sb[i].sig);
        checks++;
        assert (obs === sb[i].val) else begin
          errors++;
          $error("[TB] FAIL %s (cycle %0d): got=%0d want=%0d",
                 sb[i].tag, cyc, obs, sb[i].val);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge
  task automatic tick();
    #4;
    check_output();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    $display("[TB] pipe_ctrl directed sequence start");
    rst = 1'b1;
    // c0, c1: reset
    apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    push_exp(0, "rst_pcwrite",  S_PCWRITE,   3'd1);
    push_exp(0, "rst_ifid",     S_IFIDWRITE, 3'd1);
    push_exp(0, "rst_regwrite", S_REGWRITE,  3'd0);
    push_exp(0, "rst_memwrite", S_MEMWRITE,  3'd0);
    push_exp(0, "rst_jmp",      S_JMP,       3'd0);
    push_exp(0, "rst_bubble",   S_BUBBLE,    3'd0);
    push_exp(0, "rst_pcsrc",    S_PCSRC,     3'd0);
    push_exp(0, "rst_aluop",    S_ALUOP,     3'd0);
    push_exp(0, "rst_sela",     S_SELA,      3'd0);
    tick();
    rst = 1'b0;

    // c2: add r3,r1,r2
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "add_regdst",   S_REGDST,   3'd1);
    push_exp(1, "add_aluop",    S_ALUOP,    3'd0);
    push_exp(3, "add_regwrite", S_REGWRITE, 3'd1);
    tick();
    // c3: sub r4,r3,r1
    apply_stimulus(OPC_RTYPE, FUNC_SUB, 5'd3, 5'd1, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
    push_exp(1, "sub_aluop", S_ALUOP, 3'd1);
    tick();
    // c4: sub in EX, add in MEM; decode or r5,r3,r6
    apply_stimulus(OPC_RTYPE, FUNC_OR, 5'd3, 5'd6, 5'd3, 5'd1, 5'd3, 5'd0, 1'b0);
    push_exp(0, "fwd_exmem_selA", S_SELA,  3'd2);
    push_exp(0, "fwd_exmem_selB", S_SELB,  3'd0);
    push_exp(1, "or_aluop",       S_ALUOP, 3'd3);
    tick();
    // c5: or in EX, add in WB
    apply_stimulus(OPC_RTYPE, 6'd0, 5'd0, 5'd0, 5'd3, 5'd6, 5'd4, 5'd3, 1'b0);
    push_exp(0, "fwd_wb_selA", S_SELA, 3'd1);
    push_exp(0, "fwd_wb_selB", S_SELB, 3'd0);
    tick();

    // c6: lw r2,0(r1)
    apply_stimulus(OPC_LW, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd5, 5'd4, 1'b0);
    push_exp(1, "lw_alusrc",   S_ALUSRC,   3'd1);
    push_exp(2, "lw_memread",  S_MEMREAD,  3'd1);
    push_exp(3, "lw_regwrite", S_REGWRITE, 3'd1);
    push_exp(3, "lw_memtoreg", S_MEMTOREG, 3'd1);
    push_exp(3, "lw_writesrc", S_WRITESRC, 3'd0);
    tick();
    // c7: add r4,r2,r5 behind the load -> stall
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd2, 5'd5, 5'd1, 5'd2, 5'd0, 5'd5, 1'b0);
    push_exp(0, "stall_pcwrite", S_PCWRITE,   3'd0);
    push_exp(0, "stall_ifid",    S_IFIDWRITE, 3'd0);
    push_exp(0, "stall_bubble",  S_BUBBLE,    3'd1);
    tick();
    // c8: add held in ID, bubble in EX
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd2, 5'd5, 5'd1, 5'd2, 5'd2, 5'd0, 1'b0);
    push_exp(0, "post_stall_pcwrite", S_PCWRITE,  3'd1);
    push_exp(0, "post_stall_bubble",  S_BUBBLE,   3'd0);
    push_exp(2, "bubble_regwrite",    S_REGWRITE, 3'd0);
    push_exp(3, "add2_regwrite",      S_REGWRITE, 3'd1);
    tick();
    // c9: add in EX, bubble in MEM, lw in WB
    apply_stimulus(OPC_RTYPE, 6'd0, 5'd0, 5'd0, 5'd2, 5'd5, 5'd2, 5'd2, 1'b0);
    push_exp(0, "ldfwd_selA", S_SELA, 3'd1);
    push_exp(0, "ldfwd_selB", S_SELB, 3'd0);
    tick();
    // c10
    apply_stimulus(OPC_RTYPE, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 1'b0);
    tick();

    // c11: beq r1,r2
    apply_stimulus(OPC_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd4, 1'b0);
    push_exp(1, "beq_aluop",  S_ALUOP,  3'd1);
    push_exp(1, "beq_regdst", S_REGDST, 3'd0);
    tick();
    // c12: younger add
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd0, 1'b0);
    tick();
    // c13: beq taken in MEM; younger sw in ID
    apply_stimulus(OPC_SW, 6'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 1'b1);
    push_exp(0, "beq_pcsrc",       S_PCSRC,    3'd1);
    push_exp(0, "beq_jmp",         S_JMP,      3'd0);
    push_exp(0, "redir_pcwrite",   S_PCWRITE,  3'd1);
    push_exp(1, "sq_ex_regdst",    S_REGDST,   3'd0);
    push_exp(1, "sq_mem_memread",  S_MEMREAD,  3'd0);
    push_exp(1, "sq_mem_memwrite", S_MEMWRITE, 3'd0);
    push_exp(2, "sq_wb_regwrite",  S_REGWRITE, 3'd0);
    push_exp(2, "sq_id_memwrite",  S_MEMWRITE, 3'd0);
    tick();
    // c14: instruction fetched in the redirect cycle, must be killed
    apply_stimulus(OPC_SW, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(0, "kill_bubble",   S_BUBBLE,   3'd0);
    push_exp(1, "kill_alusrc",   S_ALUSRC,   3'd0);
    push_exp(2, "kill_memwrite", S_MEMWRITE, 3'd0);
    tick();
    // c15: slti
    apply_stimulus(OPC_SLTI, 6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "slti_alusrc",   S_ALUSRC,   3'd1);
    push_exp(1, "slti_aluop",    S_ALUOP,    3'd4);
    push_exp(3, "slti_regwrite", S_REGWRITE, 3'd1);
    tick();
    // c16: and
    apply_stimulus(OPC_RTYPE, FUNC_AND, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "and_aluop", S_ALUOP, 3'd2);
    tick();

    // c17: jal
    apply_stimulus(OPC_JAL, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "jal_jmp",      S_JMP,      3'd1);
    push_exp(1, "jal_selwrite", S_SELWRITE, 3'd1);
    push_exp(1, "jal_jorjr",    S_JORJR,    3'd0);
    push_exp(3, "jal_regwrite", S_REGWRITE, 3'd1);
    push_exp(3, "jal_writesrc", S_WRITESRC, 3'd1);
    push_exp(3, "jal_memtoreg", S_MEMTOREG, 3'd0);
    tick();
    // c18: jal in EX; younger add squashed
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(0, "jal_redir_pcwrite", S_PCWRITE,  3'd1);
    push_exp(1, "jsq_regdst",        S_REGDST,   3'd0);
    push_exp(1, "jsq_jmp",           S_JMP,      3'd0);
    push_exp(3, "jsq_regwrite",      S_REGWRITE, 3'd0);
    tick();
    // c19: addi fetched in the redirect cycle, killed
    apply_stimulus(OPC_ADDI, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "jkill_alusrc",   S_ALUSRC,   3'd0);
    push_exp(3, "jkill_regwrite", S_REGWRITE, 3'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
    end

    // c23: beq, c24: j, c25: beq taken in MEM while j in EX
    apply_stimulus(OPC_BEQ, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    apply_stimulus(OPC_J, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    push_exp(0, "br_over_j_pcsrc", S_PCSRC, 3'd1);
    push_exp(0, "br_over_j_jmp",   S_JMP,   3'd0);
    tick();
    apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // c27: unsupported opcode decodes as NOP
    apply_stimulus(6'b111111, FUNC_ADD, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "bad_opc_regdst",   S_REGDST,   3'd0);
    push_exp(1, "bad_opc_alusrc",   S_ALUSRC,   3'd0);
    push_exp(1, "bad_opc_jmp",      S_JMP,      3'd0);
    push_exp(3, "bad_opc_regwrite", S_REGWRITE, 3'd0);
    tick();
    // c28: jr
    apply_stimulus(OPC_RTYPE, FUNC_JR, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    push_exp(1, "jr_jmp",      S_JMP,      3'd1);
    push_exp(1, "jr_jorjr",    S_JORJR,    3'd1);
    push_exp(3, "jr_regwrite", S_REGWRITE, 3'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
    end

    // c32: add, c33: sw, c34: lw with reset asserted
    apply_stimulus(OPC_RTYPE, FUNC_ADD, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    apply_stimulus(OPC_SW, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b1;
    apply_stimulus(OPC_LW, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    // c35: every in-flight control discarded, lw would otherwise stall here
    rst = 1'b0;
    apply_stimulus(6'd0, 6'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1);
    push_exp(0, "mrst_regwrite", S_REGWRITE,  3'd0);
    push_exp(0, "mrst_memwrite", S_MEMWRITE,  3'd0);
    push_exp(0, "mrst_pcsrc",    S_PCSRC,     3'd0);
    push_exp(0, "mrst_pcwrite",  S_PCWRITE,   3'd1);
    push_exp(0, "mrst_ifid",     S_IFIDWRITE, 3'd1);
    push_exp(0, "mrst_bubble",   S_BUBBLE,    3'd0);
    push_exp(0, "mrst_alusrc",   S_ALUSRC,    3'd0);
    tick();
    apply_stimulus(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: got=%0d want=0 entries left", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
